// File: rtl/singlecycle_pkg.sv
// Shared types for the RV32I core: register index width, LSU access
// encodings and the LSU transaction state machine.
package singlecycle_pkg;

  localparam int REGIDX_WIDTH = 5;

  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } lsu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational data-path helpers for memory accesses: legality/alignment
// check, store lane replication and byte enables, load extraction/extension.
module lsu_align
  import singlecycle_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wsrc,
  output logic        o_legal,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  function automatic logic signed [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    return sgn ? {{24{b[7]}}, b} : {24'd0, b};
  endfunction

  function automatic logic signed [31:0] ext_half(input logic [15:0] h, input logic sgn);
    return sgn ? {{16{h[15]}}, h} : {16'd0, h};
  endfunction

  lsu_op_e     st_op;
  lsu_op_e     ld_op;
  logic [31:0] shifted;

  always_comb begin
    st_op   = lsu_op_e'(i_funct3);
    o_legal = 1'b0;
    o_wdata = i_wsrc;
    o_wstrb = 4'b0000;
    case (st_op)
      LSU_B: begin
        o_legal = 1'b1;
        o_wdata = {4{i_wsrc[7:0]}};
        o_wstrb = 4'b0001 << i_off;
      end
      LSU_H: begin
        o_legal = ~i_off[0];
        o_wdata = {2{i_wsrc[15:0]}};
        o_wstrb = 4'b0011 << i_off;
      end
      LSU_W: begin
        o_legal = (i_off == 2'b00);
        o_wstrb = 4'b1111;
      end
      LSU_BU:  o_legal = ~i_we;
      LSU_HU:  o_legal = ~i_we & ~i_off[0];
      default: o_legal = 1'b0;
    endcase
    // Reads never drive byte enables.
    if (!i_we) o_wstrb = 4'b0000;
  end

  always_comb begin
    ld_op     = lsu_op_e'(i_ld_funct3);
    shifted   = i_rdata >> {i_ld_off, 3'b000};
    o_ld_data = shifted;
    case (ld_op)
      LSU_B:   o_ld_data = ext_byte(shifted[7:0], 1'b1);
      LSU_H:   o_ld_data = ext_half(shifted[15:0], 1'b1);
      LSU_BU:  o_ld_data = ext_byte(shifted[7:0], 1'b0);
      LSU_HU:  o_ld_data = ext_half(shifted[15:0], 1'b0);
      default: o_ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one outstanding valid/ready memory transaction at a
// time, stalling the core until the access completes.
module lsu #(
  parameter int REGIDX_WIDTH = singlecycle_pkg::REGIDX_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req,
  input  logic                    i_we,
  input  logic [2:0]              i_funct3,
  input  logic [31:0]             i_rs1_data,
  input  logic [31:0]             i_imm,
  input  logic [31:0]             i_rs2_data,
  input  logic [REGIDX_WIDTH-1:0] i_rd_addr,
  output logic                    o_stall,
  output logic                    o_misalign,
  output logic                    o_mem_valid,
  input  logic                    i_mem_ready,
  output logic                    o_mem_we,
  output logic [31:0]             o_mem_addr,
  output logic [31:0]             o_mem_wdata,
  output logic [3:0]              o_mem_wstrb,
  input  logic                    i_mem_rvalid,
  input  logic [31:0]             i_mem_rdata,
  output logic                    o_rd_wen,
  output logic [REGIDX_WIDTH-1:0] o_rd_addr,
  output logic [31:0]             o_rd_data
);
  import singlecycle_pkg::*;

  lsu_state_e state_q, state_d;

  logic signed [31:0]      ea_p0;
  logic                    legal_p0;
  logic [31:0]             wdata_p0;
  logic [3:0]              wstrb_p0;
  logic [31:0]             ld_data_p0;

  logic                    mem_valid_p1;
  logic                    mem_we_p1;
  logic [31:0]             mem_addr_p1;
  logic [31:0]             mem_wdata_p1;
  logic [3:0]              mem_wstrb_p1;
  logic [2:0]              ld_op_p1;
  logic [1:0]              ld_off_p1;
  logic [REGIDX_WIDTH-1:0] rd_addr_p1;
  logic                    rd_wen_p1;
  logic [31:0]             rd_data_p1;

  assign ea_p0 = $signed(i_rs1_data) + $signed(i_imm);

  lsu_align u_align (
    .i_we        (i_we),
    .i_funct3    (i_funct3),
    .i_off       (ea_p0[1:0]),
    .i_wsrc      (i_rs2_data),
    .o_legal     (legal_p0),
    .o_wdata     (wdata_p0),
    .o_wstrb     (wstrb_p0),
    .i_ld_funct3 (ld_op_p1),
    .i_ld_off    (ld_off_p1),
    .i_rdata     (i_mem_rdata),
    .o_ld_data   (ld_data_p0)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    o_stall    = 1'b0;
    o_misalign = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          if (legal_p0) begin
            o_stall = 1'b1;
            state_d = REQ;
          end else begin
            o_misalign = 1'b1;
          end
        end
      end
      REQ: begin
        o_stall = 1'b1;
        if (i_mem_ready) state_d = mem_we_p1 ? DONE : WAIT;
      end
      WAIT: begin
        o_stall = 1'b1;
        if (i_mem_rvalid) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // stage p1: request fields latched at issue, load result captured in WAIT
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem_valid_p1 <= 1'b0;
      mem_we_p1    <= 1'b0;
      mem_addr_p1  <= '0;
      mem_wdata_p1 <= '0;
      mem_wstrb_p1 <= '0;
      ld_op_p1     <= '0;
      ld_off_p1    <= '0;
      rd_addr_p1   <= '0;
      rd_wen_p1    <= 1'b0;
      rd_data_p1   <= '0;
    end else begin
      rd_wen_p1 <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req && legal_p0) begin
            mem_valid_p1 <= 1'b1;
            mem_we_p1    <= i_we;
            mem_addr_p1  <= {ea_p0[31:2], 2'b00};
            mem_wdata_p1 <= wdata_p0;
            mem_wstrb_p1 <= wstrb_p0;
            ld_op_p1     <= i_funct3;
            ld_off_p1    <= ea_p0[1:0];
            rd_addr_p1   <= i_rd_addr;
          end
        end
        REQ: begin
          if (i_mem_ready) mem_valid_p1 <= 1'b0;
        end
        WAIT: begin
          if (i_mem_rvalid) begin
            rd_data_p1 <= ld_data_p0;
            rd_wen_p1  <= (rd_addr_p1 != '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_mem_valid = mem_valid_p1;
  assign o_mem_we    = mem_we_p1;
  assign o_mem_addr  = mem_addr_p1;
  assign o_mem_wdata = mem_wdata_p1;
  assign o_mem_wstrb = mem_wstrb_p1;
  assign o_rd_wen    = rd_wen_p1;
  assign o_rd_addr   = rd_addr_p1;
  assign o_rd_data   = rd_data_p1;

endmodule

// File: tb/tb_lsu.sv
// Directed-vector bench for the load/store unit.
module tb_lsu;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1_data, i_imm, i_rs2_data;
  logic [4:0]  i_rd_addr;
  logic        o_stall, o_misalign, o_mem_valid, i_mem_ready, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_wstrb;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_rd_wen;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;

  always #5 i_clk = ~i_clk;

  lsu dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_funct3(i_funct3),
    .i_rs1_data(i_rs1_data), .i_imm(i_imm), .i_rs2_data(i_rs2_data), .i_rd_addr(i_rd_addr),
    .o_stall(o_stall), .o_misalign(o_misalign), .o_mem_valid(o_mem_valid),
    .i_mem_ready(i_mem_ready), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb), .i_mem_rvalid(i_mem_rvalid),
    .i_mem_rdata(i_mem_rdata), .o_rd_wen(o_rd_wen), .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          rdy_dly;
    int          rv_dly;
    logic        e_mis;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    int          e_stall;
    logic        e_wen;
    logic [31:0] e_data;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cycles, stall_cnt, mis_cnt, valid_cnt, rdy_cnt, since, bad_idle;
    logic done, accepted, we_cap, wen_cap;
    logic [31:0] addr_cap, wdata_cap, data_cap;
    logic [3:0] wstrb_cap;
    logic [4:0] rda_cap;
    string tag;
    tag = $sformatf("v%0d", idx);
    cycles = 0; stall_cnt = 0; mis_cnt = 0; valid_cnt = 0; rdy_cnt = 0; since = 0;
    done = 1'b0; accepted = 1'b0; we_cap = 1'b0; wen_cap = 1'b0;
    addr_cap = '0; wdata_cap = '0; data_cap = '0; wstrb_cap = '0; rda_cap = '0;
    @(negedge i_clk);
    i_req = 1'b1; i_we = v.we; i_funct3 = v.f3; i_rs1_data = v.rs1; i_imm = v.imm;
    i_rs2_data = v.rs2; i_rd_addr = v.rd;
    while (!done && cycles < 200) begin
      #1;
      i_mem_ready = 1'b0;
      i_mem_rvalid = 1'b0;
      if (o_misalign) mis_cnt++;
      if (o_mem_valid) begin
        valid_cnt++;
        addr_cap = o_mem_addr; wdata_cap = o_mem_wdata; wstrb_cap = o_mem_wstrb; we_cap = o_mem_we;
        if (rdy_cnt >= v.rdy_dly) begin
          i_mem_ready = 1'b1;
          accepted = 1'b1;
        end else begin
          rdy_cnt++;
        end
      end else if (accepted && !v.we) begin
        since++;
        if (since == v.rv_dly) begin
          i_mem_rvalid = 1'b1;
          i_mem_rdata = v.rdata;
        end
      end
      if (o_stall) begin
        stall_cnt++;
      end else if (stall_cnt > 0 || o_misalign) begin
        done = 1'b1;
        wen_cap = o_rd_wen; rda_cap = o_rd_addr; data_cap = o_rd_data;
        i_req = 1'b0;
      end
      cycles++;
      @(negedge i_clk);
    end
    i_req = 1'b0; i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
    chk({tag, "_timeout"}, {31'd0, done}, 32'd1);
    chk({tag, "_misalign"}, mis_cnt, v.e_mis ? 32'd1 : 32'd0);
    chk({tag, "_stall_cycles"}, stall_cnt, v.e_stall);
    chk({tag, "_valid_cycles"}, valid_cnt, v.e_mis ? 32'd0 : v.rdy_dly + 1);
    if (!v.e_mis) begin
      chk({tag, "_addr"}, addr_cap, v.e_addr);
      chk({tag, "_we"}, {31'd0, we_cap}, {31'd0, v.we});
      chk({tag, "_wstrb"}, {28'd0, wstrb_cap}, {28'd0, v.e_wstrb});
      if (v.we) chk({tag, "_wdata"}, wdata_cap, v.e_wdata);
    end
    chk({tag, "_rd_wen"}, {31'd0, wen_cap}, {31'd0, v.e_wen});
    if (v.e_wen) begin
      chk({tag, "_rd_data"}, data_cap, v.e_data);
      chk({tag, "_rd_addr"}, {27'd0, rda_cap}, {27'd0, v.rd});
    end
    bad_idle = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      if (o_mem_valid || o_rd_wen || o_stall || o_misalign) bad_idle++;
      @(negedge i_clk);
    end
    chk({tag, "_quiet_after"}, bad_idle, 32'd0);
  endtask

  initial begin
    int bad;
    //           we    f3      rs1           imm           rs2           rd     rdata         rdy rv mis  addr          wdata         wstrb    st wen  data
    vecs[0]  = '{1'b1, 3'b010, 32'h0000_1000, 32'h0000_0004, 32'hDEAD_BEEF, 5'd5,  32'h0,        0, 0, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 4'b1111, 2, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 3'b000, 32'h0000_1000, 32'h0000_0003, 32'h0000_00A5, 5'd5,  32'h0,        0, 0, 1'b0, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000, 2, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 3'b000, 32'h0000_2000, 32'h0000_0002, 32'h0,         5'd7,  32'h12F4_5678, 0, 3, 1'b0, 32'h0000_2000, 32'h0,         4'b0000, 5, 1'b1, 32'hFFFF_FFF4};
    vecs[3]  = '{1'b0, 3'b100, 32'h0000_2000, 32'h0000_0002, 32'h0,         5'd8,  32'h12F4_5678, 0, 3, 1'b0, 32'h0000_2000, 32'h0,         4'b0000, 5, 1'b1, 32'h0000_00F4};
    vecs[4]  = '{1'b0, 3'b001, 32'h0000_2000, 32'h0000_0001, 32'h0,         5'd7,  32'h0,        0, 1, 1'b1, 32'h0,         32'h0,         4'b0000, 0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 3'b010, 32'h0000_2000, 32'h0000_0002, 32'h0,         5'd7,  32'h0,        0, 1, 1'b1, 32'h0,         32'h0,         4'b0000, 0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 3'b010, 32'h0000_2000, 32'h0000_0004, 32'h0,         5'd0,  32'h1122_3344, 0, 1, 1'b0, 32'h0000_2004, 32'h0,         4'b0000, 3, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 3'b001, 32'h0000_1000, 32'h0000_0002, 32'h1234_BEEF, 5'd1,  32'h0,        2, 0, 1'b0, 32'h0000_1000, 32'hBEEF_BEEF, 4'b1100, 4, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 3'b101, 32'h0000_3000, 32'h0000_0002, 32'h0,         5'd3,  32'h8765_4321, 0, 1, 1'b0, 32'h0000_3000, 32'h0,         4'b0000, 3, 1'b1, 32'h0000_8765};
    vecs[9]  = '{1'b0, 3'b001, 32'h0000_3000, 32'h0000_0002, 32'h0,         5'd10, 32'h8765_4321, 1, 1, 1'b0, 32'h0000_3000, 32'h0,         4'b0000, 4, 1'b1, 32'hFFFF_8765};
    vecs[10] = '{1'b0, 3'b010, 32'h0000_3008, 32'hFFFF_FFF8, 32'h0,         5'd31, 32'hCAFE_F00D, 0, 2, 1'b0, 32'h0000_3000, 32'h0,         4'b0000, 4, 1'b1, 32'hCAFE_F00D};
    vecs[11] = '{1'b0, 3'b011, 32'h0000_3000, 32'h0000_0000, 32'h0,         5'd4,  32'h0,        0, 1, 1'b1, 32'h0,         32'h0,         4'b0000, 0, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 3'b100, 32'h0000_3000, 32'h0000_0000, 32'h0000_0055, 5'd4,  32'h0,        0, 0, 1'b1, 32'h0,         32'h0,         4'b0000, 0, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 3'b000, 32'h0000_2000, 32'h0000_0001, 32'h0,         5'd9,  32'h12F4_5678, 0, 1, 1'b0, 32'h0000_2000, 32'h0,         4'b0000, 3, 1'b1, 32'h0000_0056};

    i_rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'b0; i_rs1_data = '0; i_imm = '0;
    i_rs2_data = '0; i_rd_addr = '0; i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    #13;
    bad = 0;
    if (o_stall || o_misalign || o_mem_valid || o_mem_we || o_rd_wen) bad++;
    if (o_mem_addr != 0 || o_mem_wdata != 0 || o_mem_wstrb != 0 || o_rd_addr != 0 || o_rd_data != 0) bad++;
    chk("reset_outputs", bad, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Reset while waiting for read data; the late response must be dropped.
    @(negedge i_clk);
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_rs1_data = 32'h4000; i_imm = 32'h0; i_rd_addr = 5'd4;
    @(negedge i_clk);
    #1;
    chk("rst_seq_req_valid", {31'd0, o_mem_valid}, 32'd1);
    i_mem_ready = 1'b1;
    @(negedge i_clk);
    i_mem_ready = 1'b0;
    @(negedge i_clk);
    #1;
    chk("rst_seq_wait_stall", {31'd0, o_stall}, 32'd1);
    #1;
    i_req = 1'b0;
    i_rst = 1'b1;
    #1;
    bad = 0;
    if (o_stall || o_misalign || o_mem_valid || o_mem_we || o_rd_wen) bad++;
    if (o_mem_addr != 0 || o_mem_wdata != 0 || o_mem_wstrb != 0 || o_rd_addr != 0 || o_rd_data != 0) bad++;
    chk("rst_seq_async_clear", bad, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h5555_AAAA;
    @(negedge i_clk);
    i_mem_rvalid = 1'b0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (o_rd_wen || o_stall || o_mem_valid || o_rd_data != 0) bad++;
      @(negedge i_clk);
    end
    chk("rst_seq_late_rvalid_ignored", bad, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
